memory_controller: RTL and testbench
====================================

Name: memory_controller

Overview:
- Core-side memory access sequencer; the writer end of the instruction/read-data register path.
- Accepts a fetch/load/store request from the control unit, drives the external memory bus and waits for `mem_ready`.
- On a read, formats the returned word and issues a one-cycle load strobe plus data to the instruction register.
- Sits between the control unit / address register and the external memory port.

Parameters:
- TIMEOUT, 15: maximum cycles spent in ACCESS without `mem_ready` before the transfer aborts; range 1..255.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  1  access request from control unit; sampled only in IDLE
- we  input  1  1 = store, 0 = read (fetch/load)
- byte  input  1  1 = byte access, 0 = word access
- addr  input  32  byte address of the access
- wdata  input  32  store data (B bus value)
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse: transfer completed (read or write)
- abort  output  1  one-cycle pulse: transfer timed out
- irload  output  1  one-cycle pulse on read completion; drives the instruction register load enable
- rdata  output  32  formatted read data to the instruction register input
- mem_addr  output  32  word-aligned memory address
- mem_wdata  output  32  memory write data
- mem_be  output  4  byte-lane enables
- mem_rd  output  1  memory read strobe
- mem_wr  output  1  memory write strobe
- mem_ready  input  1  memory completes the current access this cycle
- mem_rdata  input  32  memory read data, valid when `mem_ready`=1

Behaviour:
- Reset (synchronous, active-high): state = IDLE; every output and internal register = 0, including `rdata`, `mem_*` and the wait counter.
- Reset mid-transfer: `mem_rd`/`mem_wr` drop at that edge; no `done`, `abort` or `irload` is produced; `rdata` is cleared.
- FSM states: IDLE, ACCESS, RESP, ABORT.
- IDLE:
  - `busy` = 0.
  - If `req` = 1, latch `addr`, `we`, `byte`, `wdata` into internal registers; go to ACCESS.
  - `req` in any other state is ignored; it is not queued.
- ACCESS:
  - `mem_addr` = {addr[31:2], 2'b00}.
  - `mem_rd` = !we and `mem_wr` = we, held for the whole state.
  - `mem_be` = 4'b1111 for a word access, or 1 << addr[1:0] for a byte access.
  - `mem_wdata` = `wdata` for a word access, or {4{wdata[7:0]}} for a byte access.
  - Wait counter clears on entry and increments each cycle `mem_ready` = 0.
  - If `mem_ready` = 1: on a read, capture the formatted data into `rdata`; go to RESP.
  - Else if the counter equals TIMEOUT-1: go to ABORT.
  - `mem_ready` has priority over timeout in the same cycle.
- Read formatting:
  - Word read: `mem_rdata` rotated right by 8*addr[1:0] (unaligned-load rotation); aligned word passes unchanged.
  - Byte read: lane addr[1:0] of `mem_rdata`, zero-extended to 32 bits.
- RESP: `done` = 1; `irload` = !we; all `mem_*` strobes = 0; go to IDLE next cycle.
- ABORT: `abort` = 1; `rdata` unchanged; no `irload`; strobes = 0; go to IDLE.
- `rdata` holds its value until the next successful read; stores never modify it.
- Latency:
  - `req` sampled at edge 0 → `mem_rd`/`mem_wr` high during cycle 1.
  - `mem_ready` seen at edge 1 → `done`/`irload` during cycle 2.
  - Next `req` accepted at edge 3.
  - Zero-wait throughput is one access per 3 cycles.
- Each extra wait cycle adds one cycle. Abort asserts after TIMEOUT cycles in ACCESS.
- `mem_addr`, `mem_be` and `mem_wdata` are 0 outside ACCESS.

Test Plan:
- Reset, then word read at addr 0x100 with `mem_rdata` = 0xE3A01005 and `mem_ready` = 1 on the first ACCESS cycle → `mem_rd` in cycle 1 with `mem_addr` = 0x100 and `mem_be` = 4'hF; `irload`/`done` in cycle 2; `rdata` = 0xE3A01005.
- Byte read at addr 0x203 with `mem_rdata` = 0xAABBCCDD and 3 wait cycles → `mem_addr` = 0x200, `mem_be` = 4'b1000; `irload` 5 cycles after `req`; `rdata` = 0x000000AA.
- Unaligned word read at addr 0x102 with `mem_rdata` = 0x11223344 → `rdata` = 0x33441122.
- Byte store at addr 0x301 with `wdata` = 0x12345678 → `mem_wr` = 1, `mem_be` = 4'b0010, `mem_wdata` = 0x78787878; `done` = 1 and `irload` = 0; `rdata` unchanged from the previous read.
- TIMEOUT=4, `mem_ready` held 0 → `mem_rd` high for exactly 4 cycles, then `abort` = 1 for one cycle, no `done`/`irload`, `busy` = 0 the following cycle. A `req` pulsed during ACCESS is ignored.
- `reset` asserted in the second ACCESS cycle of a read → `mem_rd` = 0 and all outputs 0 after that edge; state IDLE; a new `req` is then accepted normally.

Source files
------------

// File: rtl/memory_controller.sv
// Core-side memory access sequencer: takes fetch/load/store requests, drives the
// external memory bus until mem_ready_i, and hands formatted read data to the IR.
module memory_controller #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic        byte_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        abort_o,
  output logic        irload_o,
  output logic [31:0] rdata_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ABORT} state_e;

  localparam logic [7:0] LastWait = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic        we_q;
  logic        byte_q;
  logic [1:0]  lane_q;
  logic [7:0]  wait_q;
  logic        busy_q;
  logic        done_q;
  logic        abort_q;
  logic        irload_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic        mem_rd_q;
  logic        mem_wr_q;

  logic [3:0]  mem_be_d;
  logic [31:0] mem_wdata_d;
  logic [31:0] rdata_d;
  logic [31:0] rot_word;
  logic [7:0]  lane_byte;

  // Bus lane setup comes straight from the request; read formatting uses the latched lane.
  always_comb begin
    mem_be_d    = byte_i ? (4'b0001 << addr_i[1:0]) : 4'b1111;
    mem_wdata_d = byte_i ? {4{wdata_i[7:0]}} : wdata_i;
    rot_word    = mem_rdata_i;
    lane_byte   = mem_rdata_i[7:0];
    case (lane_q)
      2'd1: begin
        rot_word  = {mem_rdata_i[7:0], mem_rdata_i[31:8]};
        lane_byte = mem_rdata_i[15:8];
      end
      2'd2: begin
        rot_word  = {mem_rdata_i[15:0], mem_rdata_i[31:16]};
        lane_byte = mem_rdata_i[23:16];
      end
      2'd3: begin
        rot_word  = {mem_rdata_i[23:0], mem_rdata_i[31:24]};
        lane_byte = mem_rdata_i[31:24];
      end
      default: begin
        rot_word  = mem_rdata_i;
        lane_byte = mem_rdata_i[7:0];
      end
    endcase
    rdata_d = byte_q ? {24'h000000, lane_byte} : rot_word;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      byte_q      <= 1'b0;
      lane_q      <= 2'd0;
      wait_q      <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      irload_q    <= 1'b0;
      rdata_q     <= 32'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'h0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      irload_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            state_q     <= ACCESS;
            busy_q      <= 1'b1;
            we_q        <= we_i;
            byte_q      <= byte_i;
            lane_q      <= addr_i[1:0];
            wait_q      <= 8'd0;
            mem_addr_q  <= {addr_i[31:2], 2'b00};
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_q    <= !we_i;
            mem_wr_q    <= we_i;
          end
        end
        ACCESS: begin
          // A ready response in the last allowed cycle still wins over the timeout.
          if (mem_ready_i) begin
            state_q  <= RESP;
            done_q   <= 1'b1;
            irload_q <= !we_q;
            if (!we_q) begin
              rdata_q <= rdata_d;
            end
          end else if (wait_q == LastWait) begin
            state_q <= ABORT;
            abort_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
          if (mem_ready_i || (wait_q == LastWait)) begin
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_be_q    <= 4'h0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
          end
        end
        RESP, ABORT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign abort_o     = abort_q;
  assign irload_o    = irload_q;
  assign rdata_o     = rdata_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_be_o    = mem_be_q;
  assign mem_rd_o    = mem_rd_q;
  assign mem_wr_o    = mem_wr_q;

endmodule

// File: tb/tb_memory_controller.sv
// Bench for memory_controller: hand vectors, randomized transfers against a
// transaction-level model, plus reset-during-access and ignored-request sequences.
module tb_memory_controller;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic        byteAcc;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        abortP;
  logic        irload;
  logic [31:0] rdata;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [3:0]  memBe;
  logic        memRd;
  logic        memWr;
  logic        memReady;
  logic [31:0] memRdata;

  always #5 clk = ~clk;

  memory_controller #(.TIMEOUT(TO)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_i       (req),
    .we_i        (we),
    .byte_i      (byteAcc),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .busy_o      (busy),
    .done_o      (done),
    .abort_o     (abortP),
    .irload_o    (irload),
    .rdata_o     (rdata),
    .mem_addr_o  (memAddr),
    .mem_wdata_o (memWdata),
    .mem_be_o    (memBe),
    .mem_rd_o    (memRd),
    .mem_wr_o    (memWr),
    .mem_ready_i (memReady),
    .mem_rdata_i (memRdata)
  );

  typedef struct {
    logic        we;
    logic        bt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] memData;
    int          waits;
    logic        glitch;
    logic [31:0] expRdata;
    logic [3:0]  expBe;
    logic [31:0] expMemAddr;
    logic [31:0] expMemWdata;
    int          expEnd;
    logic        expAbort;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] modelRdata;

  int          obsAccess, obsEnd, obsDone, obsIrload, obsAbort;
  logic [31:0] obsAddr, obsWdata, obsRdata;
  logic [3:0]  obsBe;
  logic [2:0]  obsStrobe;
  logic        obsEndBusZero, obsBusyAfter;

  function automatic vec_t mkVec(logic vwe, logic vbt, logic [31:0] vaddr, logic [31:0] vwdata,
                                 logic [31:0] vmem, int vwaits, logic vglitch, logic [31:0] eRdata,
                                 logic [3:0] eBe, logic [31:0] eAddr, logic [31:0] eWdata,
                                 int eEnd, logic eAbort);
    vec_t v;
    v.we = vwe; v.bt = vbt; v.addr = vaddr; v.wdata = vwdata; v.memData = vmem;
    v.waits = vwaits; v.glitch = vglitch; v.expRdata = eRdata; v.expBe = eBe;
    v.expMemAddr = eAddr; v.expMemWdata = eWdata; v.expEnd = eEnd; v.expAbort = eAbort;
    return v;
  endfunction

  // Reference model: what one whole transfer should look like from the outside.
  function automatic vec_t buildVec(logic vwe, logic vbt, logic [31:0] vaddr, logic [31:0] vwdata,
                                    logic [31:0] vmem, int vwaits, logic [31:0] prevRdata);
    vec_t v;
    int a;
    logic [63:0] dbl;
    a = int'(vaddr[1:0]);
    dbl = {vmem, vmem};
    v.we = vwe; v.bt = vbt; v.addr = vaddr; v.wdata = vwdata; v.memData = vmem;
    v.waits = vwaits; v.glitch = 1'b0;
    v.expBe = vbt ? 4'(1 << a) : 4'hF;
    v.expMemAddr = vaddr & 32'hFFFF_FFFC;
    v.expMemWdata = vbt ? (32'h0101_0101 * {24'h0, vwdata[7:0]}) : vwdata;
    v.expAbort = (vwaits >= TO);
    v.expEnd = v.expAbort ? TO + 1 : vwaits + 2;
    if (!v.expAbort && !vwe)
      v.expRdata = vbt ? ((vmem >> (8 * a)) & 32'hFF) : 32'(dbl >> (8 * a));
    else
      v.expRdata = prevRdata;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one request and plays the memory side, recording what the DUT did.
  task automatic applyStimulus(input vec_t v);
    int cyc;
    req = 1'b1; we = v.we; byteAcc = v.bt; addr = v.addr; wdata = v.wdata;
    memReady = 1'b0;
    @(negedge clk);
    req = 1'b0;
    cyc = 1;
    obsAccess = 0; obsEnd = -1; obsDone = 0; obsIrload = 0; obsAbort = 0;
    obsEndBusZero = 1'b0; obsBusyAfter = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (cyc == 1) begin
        obsAddr = memAddr; obsWdata = memWdata; obsBe = memBe;
        obsStrobe = {busy, memRd, memWr};
      end
      if (memRd || memWr) obsAccess++;
      if (done) obsDone++;
      if (irload) obsIrload++;
      if (abortP) obsAbort++;
      if ((done || abortP) && obsEnd < 0) begin
        obsEnd = cyc;
        obsEndBusZero = (memAddr == 0) && (memWdata == 0) && (memBe == 0) && !memRd && !memWr;
      end
      if (obsEnd >= 0 && cyc == obsEnd + 1) begin
        obsBusyAfter = busy;
        obsRdata = rdata;
        break;
      end
      if ((memRd || memWr) && (obsAccess - 1 == v.waits)) begin
        memReady = 1'b1;
        memRdata = v.memData;
      end else begin
        memReady = 1'b0;
        memRdata = $urandom;
      end
      if (v.glitch && cyc == 2) begin
        req = 1'b1; addr = 32'hDEAD_0000; we = ~v.we;
      end else begin
        req = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    req = 1'b0;
    memReady = 1'b0;
  endtask

  task automatic checkVector(input vec_t v, input string tag);
    checkOutput({tag, "_mem_addr"}, obsAddr, v.expMemAddr);
    checkOutput({tag, "_mem_be"}, {28'h0, obsBe}, {28'h0, v.expBe});
    checkOutput({tag, "_mem_wdata"}, obsWdata, v.expMemWdata);
    checkOutput({tag, "_busy_rd_wr"}, {29'h0, obsStrobe}, {29'h0, 1'b1, !v.we, v.we});
    checkOutput({tag, "_access_cycles"}, obsAccess, v.expEnd - 1);
    checkOutput({tag, "_end_cycle"}, obsEnd, v.expEnd);
    checkOutput({tag, "_pulses"}, obsDone * 256 + obsIrload * 16 + obsAbort,
                (v.expAbort ? 0 : 256) + ((!v.expAbort && !v.we) ? 16 : 0) + (v.expAbort ? 1 : 0));
    checkOutput({tag, "_bus_idle_at_end"}, {31'h0, obsEndBusZero}, 32'h1);
    checkOutput({tag, "_busy_after"}, {31'h0, obsBusyAfter}, 32'h0);
    checkOutput({tag, "_rdata"}, obsRdata, v.expRdata);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl[9];
    vec_t v;
    int quiet;

    reset = 1'b1; req = 1'b0; we = 1'b0; byteAcc = 1'b0; addr = 32'h0; wdata = 32'h0;
    memReady = 1'b0; memRdata = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ctrl", {22'h0, busy, done, abortP, irload, memRd, memWr, memBe}, 32'h0);
    checkOutput("reset_rdata", rdata, 32'h0);
    checkOutput("reset_mem_addr", memAddr, 32'h0);
    checkOutput("reset_mem_wdata", memWdata, 32'h0);
    reset = 1'b0;
    modelRdata = 32'h0;
    @(negedge clk);

    tbl[0] = mkVec(0, 0, 32'h100, 32'h0,        32'hE3A01005, 0,  0, 32'hE3A01005, 4'hF, 32'h100, 32'h0,        2, 0);
    tbl[1] = mkVec(0, 1, 32'h203, 32'h55,       32'hAABBCCDD, 3,  1, 32'h000000AA, 4'h8, 32'h200, 32'h55555555, 5, 0);
    tbl[2] = mkVec(0, 0, 32'h102, 32'h0,        32'h11223344, 1,  0, 32'h33441122, 4'hF, 32'h100, 32'h0,        3, 0);
    tbl[3] = mkVec(1, 1, 32'h301, 32'h12345678, 32'hFFFFFFFF, 0,  0, 32'h33441122, 4'h2, 32'h300, 32'h78787878, 2, 0);
    tbl[4] = mkVec(1, 0, 32'h404, 32'hCAFEBABE, 32'hFFFFFFFF, 2,  0, 32'h33441122, 4'hF, 32'h404, 32'hCAFEBABE, 4, 0);
    tbl[5] = mkVec(0, 0, 32'h500, 32'h0,        32'h0,        99, 1, 32'h33441122, 4'hF, 32'h500, 32'h0,        5, 1);
    tbl[6] = mkVec(0, 1, 32'h501, 32'h0,        32'h00001234, 0,  0, 32'h00000012, 4'h2, 32'h500, 32'h0,        2, 0);
    tbl[7] = mkVec(0, 0, 32'h603, 32'h0,        32'h89ABCDEF, 3,  0, 32'hABCDEF89, 4'hF, 32'h600, 32'h0,        5, 0);
    tbl[8] = mkVec(1, 0, 32'h700, 32'h1,        32'h0,        4,  0, 32'hABCDEF89, 4'hF, 32'h700, 32'h1,        5, 1);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(tbl[i]);
      checkVector(tbl[i], $sformatf("vec%0d", i));
      modelRdata = tbl[i].expRdata;
    end

    for (int i = 0; i < 40; i++) begin
      v = buildVec(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                   $urandom, int'($urandom_range(0, 5)), modelRdata);
      applyStimulus(v);
      checkVector(v, $sformatf("rnd%0d", i));
      modelRdata = v.expRdata;
    end

    // Reset landing in the second ACCESS cycle of a read.
    req = 1'b1; we = 1'b0; byteAcc = 1'b0; addr = 32'h800; memReady = 1'b0;
    @(negedge clk);
    req = 1'b0;
    checkOutput("rstmid_rd_first", {30'h0, busy, memRd}, 32'h3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rstmid_ctrl", {22'h0, busy, done, abortP, irload, memRd, memWr, memBe}, 32'h0);
    checkOutput("rstmid_rdata", rdata, 32'h0);
    checkOutput("rstmid_mem_addr", memAddr, 32'h0);
    modelRdata = 32'h0;
    quiet = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy || done || irload || abortP || memRd) quiet++;
    end
    checkOutput("rstmid_quiet", quiet, 0);

    v = buildVec(1'b0, 1'b0, 32'h900, 32'h0, 32'h13572468, 1, modelRdata);
    applyStimulus(v);
    checkVector(v, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
